// File: rtl/plab4_net_router_output_ctrl.sv
// plab4_net_router_output_ctrl
//   Output-port controller for one ring-router port. Arbitrates round-robin
//   among three requesters and holds the winner while the output stalls,
//   so the val/rdy handshake stays stable until the transfer completes.
//
// Ports
//   clk        : clock, state updates on rising edge
//   reset      : asynchronous active-low reset
//   reqs[2:0]  : bit i set when input i requests this output
//   grants[2:0]: one-hot/zero, bit i set when input i transfers this cycle
//   out_val    : output channel valid
//   out_rdy    : output channel ready (combinational path to grants)
//   sel[1:0]   : crossbar select, index of winner, 0 when none
//   xfer_count : transfer counter, present only when
//                PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN is defined
module plab4_net_router_output_ctrl #(
   parameter int unsigned p_num_inputs = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] reqs,
   output logic [2:0] grants,
   output logic       out_val,
   input  logic       out_rdy,
   output logic [1:0] sel
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
   ,
   output logic [15:0] xfer_count
`endif
);

   typedef enum logic {ARB, HOLD} state_t;

   state_t     state, state_nxt;
   logic [2:0] prio, prio_nxt;
   logic [1:0] held, held_nxt;

   logic [1:0] prio_idx;
   logic [1:0] arb_idx;
   logic       arb_found;
   logic [1:0] win_idx;
   logic       win_found;
   logic       hold_ok;
   logic [2:0] cand;

   always_comb begin
      prio_idx = 2'd0;
      case (prio)
         3'b010:  prio_idx = 2'd1;
         3'b100:  prio_idx = 2'd2;
         default: prio_idx = 2'd0;
      endcase
   end

   // Rotating scan: first requester at or after the priority pointer, mod 3.
   always_comb begin
      arb_idx   = 2'd0;
      arb_found = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < p_num_inputs; k++) begin
         cand = {1'b0, prio_idx} + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!arb_found && reqs[cand[1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[1:0];
         end
      end
   end

   // A held winner keeps the port; if its request vanishes, fall back to
   // the scan in the same cycle rather than leaving the port idle.
   always_comb begin
      hold_ok   = (state == HOLD) && reqs[held];
      win_found = hold_ok ? 1'b1 : arb_found;
      win_idx   = hold_ok ? held : arb_idx;
   end

   always_comb begin
      out_val = win_found;
      sel     = win_found ? win_idx : 2'd0;
      grants  = '0;
      if (win_found && out_rdy) grants[win_idx] = 1'b1;
   end

   always_comb begin
      state_nxt = ARB;
      prio_nxt  = prio;
      held_nxt  = held;
      if (win_found) begin
         if (out_rdy) begin
            state_nxt = ARB;
            case (win_idx)
               2'd0:    prio_nxt = 3'b010;
               2'd1:    prio_nxt = 3'b100;
               default: prio_nxt = 3'b001;
            endcase
         end else begin
            state_nxt = HOLD;
            held_nxt  = win_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARB;
         prio  <= 3'b001;
         held  <= 2'd0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         held  <= held_nxt;
      end
   end

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) xfer_count <= '0;
      else if (|grants) xfer_count <= xfer_count + 16'd1;
   end
`endif

endmodule

// File: doc/plab4_net_router_output_ctrl.md
# plab4_net_router_output_ctrl

Output-port controller for one router port of the ring network. It sits directly downstream of the three per-input request generators and consumes their 3-bit `reqs` vectors, one bit per input. It arbitrates round-robin among the requesters and drives `grants` back to them, so each input's ready is `|(reqs & grants)`. It also drives the crossbar select and the output channel valid. Once a winner stalls on the output, the grant is held so the val/rdy contract stays stable.

## Interface
- `p_num_inputs`, 3, number of requesters; fixed at 3 in this revision.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; state clears immediately while low.
- `reqs`  in  3  bit i set means input i requests this output.
- `grants`  out  3  one-hot or zero; bit i set means input i transfers this cycle.
- `out_val`  out  1  output channel valid.
- `out_rdy`  in  1  output channel ready.
- `sel`  out  2  crossbar select, 0..2; index of the current winner, 0 when there is none.
- `xfer_count`  out  16  only with `PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN`; see Configuration.

## Operation
- State:
  - `prio[2:0]`, one-hot, marks the highest-priority input.
  - `state` ∈ {ARB, HOLD}.
  - `held[1:0]`, index of the held winner.
- Winner selection in ARB:
  - Scan `reqs` starting at index `prio` and ascending modulo 3; the first set bit wins.
  - There is no winner if `reqs == 0`.
- Winner selection in HOLD:
  - The winner is `held` if `reqs[held]` is set.
  - If `reqs[held]` has dropped (protocol violation), the block falls back to the ARB scan in the same cycle.
- Combinational outputs:
  - `out_val = (winner exists)`.
  - `sel = winner index`, or 0 when there is no winner.
  - `grants = onehot(winner) & {3{out_rdy}}`, so a grant means a transfer.
- Transitions:
  - ARB, winner w, `out_rdy=1`: transfer; `prio <= onehot((w+1) mod 3)`; stay in ARB.
  - ARB, winner w, `out_rdy=0`: `state <= HOLD`, `held <= w`; `prio` is unchanged.
  - HOLD, winner `held`, `out_rdy=1`: transfer; `prio <= onehot((held+1) mod 3)`; `state <= ARB`.
  - HOLD, winner `held`, `out_rdy=0`: stay in HOLD.
  - HOLD with `reqs[held]` dropped: behave as ARB this cycle, including the next-state update.
  - No winner in either state: `state <= ARB`; `prio` is unchanged.
- `prio` changes only on a transfer. The rotation always places the input just after the winner at the top.
- A newly arriving higher-priority request never preempts a held winner.

## Timing
- Arbitration is zero-latency: `reqs`/`out_rdy` to `grants`/`out_val`/`sel` is purely combinational within one cycle.
- There is a combinational path `out_rdy` → `grants`. Upstream logic must not loop `in_rdy` back into `reqs`.
- State updates on the rising `clk` edge, one cycle after the transfer.
- Reset values, applied asynchronously while `reset`=0:
  - `prio=3'b001`, `state=ARB`, `held=0`.
  - The outputs then follow the combinational rules. With `reqs=0` they are `grants=0`, `out_val=0`, `sel=0`.
- Reset asserted mid-HOLD: the hold is dropped immediately. After release, arbitration restarts from input 0.
- Back-to-back transfers, one per cycle, are sustained while `out_rdy=1`.

## Configuration
- `PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN` defined:
  - Adds the `xfer_count` output, a 16-bit register holding the number of transfers (cycles with `|grants`).
  - Increments at the clock edge that ends a transfer cycle.
  - Wraps from 16'hFFFF to 0.
  - Reset value is 0, cleared asynchronously with `reset`.
- Not defined: the port and counter are absent, and arbitration behaviour is identical.

## Test plan
- Reset then idle: `reset`=0 with `reqs=3'b111` → while reset is low, `prio` stays 3'b001. After release with `reqs=0`: `grants=0`, `out_val=0`, `sel=0`.
- Fairness: `reqs=3'b111`, `out_rdy=1` for 6 cycles → `grants` sequence 001, 010, 100, 001, 010, 100 and `sel` 0, 1, 2, 0, 1, 2.
- Stall hold: `reqs=3'b011`, `out_rdy=0` for 3 cycles → `out_val=1`, `sel=0`, `grants=0`. When `reqs` becomes 3'b111 during the stall, `sel` stays 0. Then `out_rdy=1` → `grants=001`, and next cycle `sel=1`.
- Protocol drop: in HOLD on input 2, drop `reqs` to 3'b001 with `out_rdy=1` → same cycle `grants=001`, `sel=0`, and next state is ARB.
- Reset mid-hold: HOLD on input 1, assert `reset`=0 asynchronously mid-cycle → `prio`=001 and `state`=ARB immediately. After release with `reqs=3'b110`, `out_rdy=1` → `grants=010`.
- Stats (macro defined): 65537 transfers → `xfer_count=1`. Without the macro, the bench compiles with no `xfer_count` port.
